// File: rtl/demux_1x4_8bits_buf_pkg.sv
// Purpose: shared constants and helpers for the 1:4 8-bit buffered demux.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_1x4_8bits_buf_pkg;

    localparam int SIZE_SEL = 2;              // select width
    localparam int SIZE_N   = 8;              // data word width
    localparam int NUM_CH   = 2 ** SIZE_SEL;  // output channels
    localparam int DEPTH    = 2;              // entries per channel FIFO
    localparam int OCC_W    = 2;              // occupancy counter width (0..2)

    // Flattened bus widths for the per-channel outputs.
    localparam int DATA_FLAT_W = NUM_CH * SIZE_N;
    localparam int OCC_FLAT_W  = NUM_CH * OCC_W;

    // Occupancy value at which a channel refuses further input.
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // One-hot decode of the destination select.
    function automatic logic [NUM_CH-1:0] sel_decode(input logic [SIZE_SEL-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_1x4_8bits_buf_chan_fifo2.sv
// Purpose: 2-entry per-channel FIFO with registered head output and occupancy count.
// Latency: a pushed word is visible at dout/valid on the following cycle (no bypass).
// Backpressure: full is raised at 2 entries; a push while full and a pop while empty are ignored.
//
// Ports: clk/rst_n (async active-low); push/din write the tail; pop consumes the head;
//        dout/valid present the head; full and occ report fill level.
module chan_fifo2
    import demux_1x4_8bits_buf_pkg::*;
#(
    parameter int W = SIZE_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             valid,
    output logic             full,
    output logic [OCC_W-1:0] occ
);

    logic [W-1:0]     mem [DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [OCC_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == OCC_FULL);
    assign valid = (cnt != '0);
    assign occ   = cnt;
    assign dout  = mem[rd_ptr];

    // Guard the strobes so a misbehaving caller cannot over/underflow the count.
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + OCC_W'(1);
                2'b01:   cnt <= cnt - OCC_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/demux_1x4_8bits_buf.sv
// Purpose: route one valid/ready word stream into four independently drained 2-deep channel FIFOs.
// Latency: accepted word reaches its channel head one cycle after the accepting edge.
// Backpressure: in_ready drops when the selected channel holds 2 words, regardless of out_ready.
//
// Ports: clk, rst_n (async active-low); in_data/in_sel/in_valid/in_ready input handshake;
//        out_data (channel i at [i*8 +: 8]), out_valid[i], out_ready[i] per-channel drain;
//        occ (channel i at [2*i +: 2]) per-channel occupancy.
module demux_1x4_8bits_buf
    import demux_1x4_8bits_buf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SIZE_N-1:0]      in_data,
    input  logic [SIZE_SEL-1:0]    in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_FLAT_W-1:0] out_data,
    output logic [NUM_CH-1:0]      out_valid,
    input  logic [NUM_CH-1:0]      out_ready,
    output logic [OCC_FLAT_W-1:0]  occ
);

    logic [NUM_CH-1:0] ch_full;
    logic [NUM_CH-1:0] ch_push;
    logic [NUM_CH-1:0] sel_onehot;

    assign sel_onehot = sel_decode(in_sel);

    // Only the selected channel's registered fill level matters; a pop on a
    // full channel this cycle does not open the door (no full-bypass).
    assign in_ready = rst_n & ~ch_full[in_sel];
    assign ch_push  = {NUM_CH{in_valid & in_ready}} & sel_onehot;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        chan_fifo2 #(
            .W (SIZE_N)
        ) u_chan_fifo2 (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (ch_push[g]),
            .din   (in_data),
            .pop   (out_ready[g]),
            .dout  (out_data[g*SIZE_N +: SIZE_N]),
            .valid (out_valid[g]),
            .full  (ch_full[g]),
            .occ   (occ[g*OCC_W +: OCC_W])
        );
    end

endmodule

// File: tb/tb_demux_1x4_8bits_buf.sv
module tb_demux_1x4_8bits_buf;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  occ;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one plain queue per channel, capacity 2.
    logic [7:0] q [4][$];

    demux_1x4_8bits_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the currently driven inputs.
    task automatic check_model();
        chk("in_ready", {31'b0, in_ready}, (rst_n && q[in_sel].size() < 2) ? 32'd1 : 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("occ%0d", i), {30'b0, occ[2*i +: 2]}, q[i].size());
            chk($sformatf("out_valid%0d", i), {31'b0, out_valid[i]},
                (q[i].size() != 0) ? 32'd1 : 32'd0);
            if (q[i].size() != 0)
                chk($sformatf("head%0d", i), {24'b0, out_data[8*i +: 8]}, {24'b0, q[i][0]});
        end
    endtask

    // Drive one cycle of inputs at posedge+1, check before the edge, advance the model.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] r);
        logic acc;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #2;
        check_model();
        acc = v && (q[s].size() < 2);
        @(posedge clk);
        for (int i = 0; i < 4; i++)
            if (r[i] && q[i].size() != 0) void'(q[i].pop_front());
        if (acc) q[s].push_back(d);
        #1;
    endtask

    initial begin
        logic       hold_v;
        logic [1:0] hold_s;
        logic [7:0] hold_d;
        logic       rv;
        logic [1:0] rs;
        logic [7:0] rd;
        logic [3:0] rr;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'h0;
        #1;
        chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
        chk("rst_occ", {24'b0, occ}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word to channel 2.
        cycle(1'b1, 2'd2, 8'hA5, 4'h0);
        cycle(1'b0, 2'd0, 8'h00, 4'h0);
        chk("a5_out_valid", {28'b0, out_valid}, 32'h4);
        chk("a5_head", {24'b0, out_data[23:16]}, 32'hA5);
        chk("a5_occ2", {30'b0, occ[5:4]}, 32'd1);

        // Fill channel 1; full refuses sel=1 but not sel=0.
        cycle(1'b1, 2'd1, 8'h11, 4'h0);
        cycle(1'b1, 2'd1, 8'h22, 4'h0);
        cycle(1'b0, 2'd1, 8'h00, 4'h0);
        chk("full_occ1", {30'b0, occ[3:2]}, 32'd2);
        chk("full_rdy_sel1", {31'b0, in_ready}, 32'd0);
        cycle(1'b0, 2'd0, 8'h00, 4'h0);
        chk("full_rdy_sel0", {31'b0, in_ready}, 32'd1);

        // Full channel popped while input waits: no bypass, then accept once occ=1.
        cycle(1'b1, 2'd1, 8'h55, 4'b0010);
        chk("nobypass_head22", {24'b0, out_data[15:8]}, 32'h22);
        chk("nobypass_occ1", {30'b0, occ[3:2]}, 32'd1);
        cycle(1'b1, 2'd1, 8'h55, 4'b0010);
        cycle(1'b0, 2'd0, 8'h00, 4'b0010);

        // Channel 3 push+pop at occ=1.
        cycle(1'b1, 2'd3, 8'h33, 4'h0);
        cycle(1'b1, 2'd3, 8'h44, 4'b1000);
        chk("pp_occ3", {30'b0, occ[7:6]}, 32'd1);
        chk("pp_head3", {24'b0, out_data[31:24]}, 32'h44);
        cycle(1'b0, 2'd0, 8'h00, 4'hF);

        // Load all four, pop all at once.
        cycle(1'b1, 2'd0, 8'h01, 4'h0);
        cycle(1'b1, 2'd1, 8'h02, 4'h0);
        cycle(1'b1, 2'd2, 8'h03, 4'h0);
        cycle(1'b1, 2'd3, 8'h04, 4'h0);
        chk("all_heads", out_data, 32'h04030201);
        cycle(1'b0, 2'd0, 8'h00, 4'hF);
        chk("all_out_valid", {28'b0, out_valid}, 32'h0);
        chk("all_occ", {24'b0, occ}, 32'h0);

        // Mid-operation asynchronous reset with channel 0 full.
        cycle(1'b1, 2'd0, 8'hC1, 4'h0);
        cycle(1'b1, 2'd0, 8'hC2, 4'h0);
        in_valid = 1'b0;
        #2;
        chk("pre_rst_occ0", {30'b0, occ[1:0]}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {28'b0, out_valid}, 32'h0);
        chk("arst_occ", {24'b0, occ}, 32'h0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'h0);
        for (int i = 0; i < 4; i++) q[i].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 2'd0, 8'h5A, 4'h0);
        cycle(1'b0, 2'd0, 8'h00, 4'h0);
        chk("post_rst_head0", {24'b0, out_data[7:0]}, 32'h5A);
        chk("post_rst_occ0", {30'b0, occ[1:0]}, 32'd1);

        // Randomized traffic; a refused word is held stable until accepted.
        hold_v = 1'b0;
        hold_s = 2'd0;
        hold_d = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if (hold_v) begin
                rv = 1'b1;
                rs = hold_s;
                rd = hold_d;
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                rs = 2'($urandom_range(0, 3));
                rd = 8'($urandom);
            end
            rr = 4'($urandom) & 4'($urandom);
            hold_v = rv && (q[rs].size() >= 2);
            hold_s = rs;
            hold_d = rd;
            cycle(rv, rs, rd, rr);
        end
        cycle(1'b0, 2'd0, 8'h00, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
